pci_host_sequencer: RTL and testbench
=====================================

PCI_HOST_SEQUENCER -- requirements
Module: pci_host_sequencer

Interface
REQ-001 Parameter RESULT_BASE, default 21'h03CF96, word address of result block for set 0.
REQ-002 Parameter RESULT_WORDS, default 4, result words read back per set (1..4).
REQ-003 Parameter TIMEOUT_CYCLES, default 32'd1_000_000, maximum wait for any flag or read response.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle request to run one job; ignored while busy=1.
REQ-007 num_words  in  21  image/template words to load; sampled with start.
REQ-008 set_sel  in  8  result set index; sampled with start.
REQ-009 src_valid / src_ready  in / out  1 / 1  load-data stream handshake.
REQ-010 src_data  in  32  load word, written to memory unmodified.
REQ-011 mem_addr  out  21  memory word address.
REQ-012 mem_wdata  out  32  memory write data.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 mem_rd_req  out  1  memory read request.
REQ-015 mem_rd_ready / mem_rd_data  in / in  1 / 32  read response valid and data.
REQ-016 flag_rdata  in  32  current contents of the shared flag word.
REQ-017 flag_we / flag_wdata  out / out  1 / 32  flag word write strobe and data.
REQ-018 res_valid / res_index / res_data  out  1 / 2 / 32  one-cycle result word strobe, index, data.
REQ-019 busy / done / timeout_err  out  1 / 1 / 1  job active; one-cycle completion pulse; timeout status.

Function
REQ-020 States SHALL be IDLE, LOAD, KICK, WAIT_ACK, WAIT_DONE, CLR, RD_REQ, RD_WAIT, FINISH, ERR.
REQ-021 IDLE: start=1 latches num_words (clamped to RESULT_BASE) and set_sel, clears timeout_err; num_words≠0 -> LOAD, else -> KICK.
REQ-022 LOAD: src_ready=1; mem_we=src_valid; mem_addr=load counter; mem_wdata=src_data; counter increments per accepted word; the cycle accepting word num_words-1 -> KICK.
REQ-023 LOAD with src_valid=0: no write, counter holds, no timeout.
REQ-024 KICK: flag_we=1, flag_wdata=32'h0001_0000 for exactly one cycle -> WAIT_ACK; wait timer cleared.
REQ-025 WAIT_ACK: flag_rdata==32'h0000_0002 -> WAIT_DONE, timer cleared; any other value keeps waiting.
REQ-026 WAIT_DONE: flag_rdata==32'h0000_0004 -> CLR.
REQ-027 CLR: flag_we=1, flag_wdata=32'h0 for one cycle -> RD_REQ; result index cleared to 0.
REQ-028 RD_REQ: mem_rd_req=1 for one cycle, mem_addr=RESULT_BASE+{set_sel,2'b00}+index (21-bit, wraps modulo 2^21) -> RD_WAIT.
REQ-029 RD_WAIT: mem_addr held; on mem_rd_ready, res_valid=1 with res_data=mem_rd_data and res_index=index for one cycle; index==RESULT_WORDS-1 -> FINISH, else index+1 -> RD_REQ.
REQ-030 FINISH: done=1 for one cycle -> IDLE.
REQ-031 Timer counts every cycle in WAIT_ACK, WAIT_DONE, RD_WAIT; reaching TIMEOUT_CYCLES -> ERR.
REQ-032 ERR: flag_we=1, flag_wdata=0 for one cycle, timeout_err set -> IDLE; timeout_err holds until next accepted start.
REQ-033 busy=1 in every state except IDLE; start while busy SHALL have no effect.
REQ-034 mem_we and mem_rd_req SHALL never be asserted in the same cycle; flag_we only in KICK, CLR, ERR.
REQ-035 Idle outputs: mem_we, mem_rd_req, flag_we, src_ready, res_valid, done = 0; mem_addr=0.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE, all counters/timer/index to 0, timeout_err=0, all outputs 0, regardless of state (including mid-LOAD or mid-read).

Verification
REQ-037 start, num_words=3, src words 0xA1,0xA2,0xA3 with one src_valid gap -> writes addr 0..2, then flag_we with 0x0001_0000 exactly once.
REQ-038 Flag model answers 0x2 after 5 cycles, 0x4 after 20; set_sel=2 -> flag cleared to 0, reads at 0x03CF9E..0x03CFA1, res_valid ×4 indices 0..3, done pulse, busy=0.
REQ-039 TIMEOUT_CYCLES=16, flag never reaches 0x2 -> ERR after 16 wait cycles, flag cleared, timeout_err=1, no res_valid, no done; next start clears timeout_err.
REQ-040 start pulses during WAIT_DONE -> ignored; exactly one job completes.
REQ-041 num_words=0 -> KICK in cycle after start, no mem_we.
REQ-042 rst_n asserted in RD_WAIT after 2 results -> all outputs 0 immediately, IDLE after release, no done.

Source files
------------

// File: rtl/pci_host_sequencer.sv
// pci_host_sequencer
//   Runs one offload job per accepted start:
//     1. stream num_words source words into memory at word addresses 0..N-1
//     2. raise the "go" value in the shared flag word
//     3. wait for the acknowledge value, then for the done value
//     4. clear the flag word
//     5. read RESULT_WORDS words of result set set_sel back out as res_* strobes
//   Every wait is bounded by TIMEOUT_CYCLES. On expiry the flag word is
//   cleared and timeout_err is raised; it stays up until the next job starts.
// Ports
//   clk, rst_n                         clock, async active-low reset
//   start, num_words, set_sel          job request (start ignored while busy)
//   src_valid/src_ready/src_data       load-data stream
//   mem_addr/mem_wdata/mem_we          memory write port (shared address)
//   mem_rd_req/mem_rd_ready/mem_rd_data memory read port
//   flag_rdata, flag_we/flag_wdata     shared flag word
//   res_valid/res_index/res_data       result word strobe
//   busy, done, timeout_err            job status
module pci_host_sequencer #(
  parameter logic [20:0] RESULT_BASE    = 21'h03CF96,
  parameter int          RESULT_WORDS   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [20:0] num_words,
  input  logic [7:0]  set_sel,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [31:0] src_data,
  output logic [20:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_rd_req,
  input  logic        mem_rd_ready,
  input  logic [31:0] mem_rd_data,
  input  logic [31:0] flag_rdata,
  output logic        flag_we,
  output logic [31:0] flag_wdata,
  output logic        res_valid,
  output logic [1:0]  res_index,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [31:0] FLAG_GO   = 32'h0001_0000;
  localparam logic [31:0] FLAG_ACK  = 32'h0000_0002;
  localparam logic [31:0] FLAG_DONE = 32'h0000_0004;
  localparam logic [1:0]  LAST_IDX  = 2'(RESULT_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, KICK, WAIT_ACK, WAIT_DONE, CLR, RD_REQ, RD_WAIT, FINISH, ERR
  } state_t;

  state_t      state;
  logic [20:0] n_words;
  logic [7:0]  set_r;
  logic [20:0] load_cnt;
  logic [31:0] timer;
  logic [1:0]  idx;
  logic [20:0] rd_addr;
  logic        tmo;

  // Address arithmetic is 21 bits wide, so a large set_sel wraps modulo 2^21.
  assign rd_addr = RESULT_BASE + {11'b0, set_r, 2'b00} + {19'b0, idx};
  // The timer counts 0..TIMEOUT_CYCLES-1; the cycle that would reach
  // TIMEOUT_CYCLES without seeing the awaited event goes to ERR.
  assign tmo     = (timer == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_words     <= '0;
      set_r       <= '0;
      load_cnt    <= '0;
      timer       <= '0;
      idx         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Clamp so the load can never run into the result area.
          n_words     <= (num_words > RESULT_BASE) ? RESULT_BASE : num_words;
          set_r       <= set_sel;
          load_cnt    <= '0;
          timeout_err <= 1'b0;
          state       <= (num_words == '0) ? KICK : LOAD;
        end
        LOAD: if (src_valid) begin
          load_cnt <= load_cnt + 21'd1;
          if (load_cnt == n_words - 21'd1) state <= KICK;
        end
        KICK: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (flag_rdata == FLAG_ACK) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (tmo) state <= ERR;
          else              timer <= timer + 32'd1;
        end
        WAIT_DONE: begin
          if (flag_rdata == FLAG_DONE) begin
            timer <= '0;
            state <= CLR;
          end else if (tmo) state <= ERR;
          else              timer <= timer + 32'd1;
        end
        CLR: begin
          idx   <= '0;
          state <= RD_REQ;
        end
        RD_REQ: begin
          timer <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rd_ready) begin
            if (idx == LAST_IDX) state <= FINISH;
            else begin
              idx   <= idx + 2'd1;
              state <= RD_REQ;
            end
          end else if (tmo) state <= ERR;
          else              timer <= timer + 32'd1;
        end
        FINISH: state <= IDLE;
        ERR: begin
          timeout_err <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly; the load path and the read
  // response pass through in the same cycle so no stream word is delayed.
  always_comb begin
    src_ready  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_rd_req = 1'b0;
    flag_we    = 1'b0;
    flag_wdata = '0;
    res_valid  = 1'b0;
    res_index  = '0;
    res_data   = '0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      LOAD: begin
        src_ready = 1'b1;
        mem_we    = src_valid;
        mem_addr  = load_cnt;
        mem_wdata = src_data;
      end
      KICK: begin
        flag_we    = 1'b1;
        flag_wdata = FLAG_GO;
      end
      CLR, ERR: flag_we = 1'b1;
      RD_REQ: begin
        mem_rd_req = 1'b1;
        mem_addr   = rd_addr;
      end
      RD_WAIT: begin
        mem_addr = rd_addr;
        if (mem_rd_ready) begin
          res_valid = 1'b1;
          res_index = idx;
          res_data  = mem_rd_data;
        end
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pci_host_sequencer.sv
// Scoreboard bench for pci_host_sequencer: expected memory writes, flag
// writes, read addresses and result words are queued when a job is launched
// and popped as the DUT produces them. A flag-word model answers ack/done
// after fixed delays, a memory model answers reads with an address-derived
// pattern two cycles after each request.
module tb_pci_host_sequencer;

  localparam logic [20:0] BASE = 21'h03CF96;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [20:0] num_words = '0;
  logic [7:0]  set_sel = '0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_ready, mem_we, mem_rd_req, mem_rd_ready, flag_we;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata, mem_rd_data, flag_rdata, flag_wdata, res_data;
  logic        res_valid, busy, done, timeout_err;
  logic [1:0]  res_index;

  pci_host_sequencer #(.RESULT_BASE(BASE), .RESULT_WORDS(4), .TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .set_sel(set_sel),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rd_req(mem_rd_req), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .flag_rdata(flag_rdata), .flag_we(flag_we), .flag_wdata(flag_wdata),
    .res_valid(res_valid), .res_index(res_index), .res_data(res_data),
    .busy(busy), .done(done), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdfn(input logic [20:0] a);
    return 32'hC0DE_0000 ^ {11'b0, a};
  endfunction

  // Flag word model: ack 5 cycles after the go value lands, done 20 after.
  logic [31:0] flag_word = '0;
  int          fcnt = 0;
  logic        flag_mode = 1'b1;
  assign flag_rdata = flag_word;
  always @(posedge clk) begin
    if (flag_we) begin
      flag_word <= flag_wdata;
      fcnt      <= 0;
    end else begin
      fcnt <= fcnt + 1;
      if (flag_mode && flag_word == 32'h0001_0000 && fcnt == 4)  flag_word <= 32'h2;
      if (flag_mode && flag_word == 32'h0000_0002 && fcnt == 19) flag_word <= 32'h4;
    end
  end

  // Memory read model, two-cycle latency, dropped by reset.
  logic [1:0]  rd_pend;
  logic [20:0] rd_a0, rd_a1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= '0; rd_a0 <= '0; rd_a1 <= '0;
    end else begin
      rd_pend <= {rd_pend[0], mem_rd_req};
      rd_a0   <= mem_addr;
      rd_a1   <= rd_a0;
    end
  end
  assign mem_rd_ready = rd_pend[1];
  assign mem_rd_data  = rd_pend[1] ? rdfn(rd_a1) : 32'h0;

  typedef struct { logic [20:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [1:0] i; logic [31:0] d; } res_t;
  wr_t         exp_wr[$];
  logic [20:0] exp_rd[$];
  res_t        exp_res[$];
  logic [31:0] exp_flag[$];

  int cyc = 0, done_cnt = 0, res_cnt = 0, kick_cnt = 0, kick_cyc = 0, clr_cyc = 0;

  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    cyc++;
    if (mem_we && mem_rd_req) chk("we_rd_excl", 32'd1, 32'd0);
    if (mem_we) begin
      if (exp_wr.size() == 0) chk("wr_unexp", 32'd1, 32'd0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", {11'b0, mem_addr}, {11'b0, w.a});
        chk("wr_data", mem_wdata, w.d);
      end
    end
    if (mem_rd_req) begin
      if (exp_rd.size() == 0) chk("rd_unexp", 32'd1, 32'd0);
      else chk("rd_addr", {11'b0, mem_addr}, {11'b0, exp_rd.pop_front()});
    end
    if (res_valid) begin
      res_cnt++;
      if (exp_res.size() == 0) chk("res_unexp", 32'd1, 32'd0);
      else begin
        r = exp_res.pop_front();
        chk("res_index", {30'b0, res_index}, {30'b0, r.i});
        chk("res_data", res_data, r.d);
      end
    end
    if (flag_we) begin
      if (flag_wdata == 32'h0001_0000) begin kick_cnt++; kick_cyc = cyc; end
      else clr_cyc = cyc;
      if (exp_flag.size() == 0) chk("flag_unexp", 32'd1, 32'd0);
      else chk("flag_wdata", flag_wdata, exp_flag.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic push_reads(input logic [7:0] sel);
    logic [20:0] a;
    res_t        r;
    for (int i = 0; i < 4; i++) begin
      a   = BASE + {11'b0, sel, 2'b00} + 21'(i);
      r.i = 2'(i);
      r.d = rdfn(a);
      exp_rd.push_back(a);
      exp_res.push_back(r);
    end
  endtask

  task automatic push_job(input logic [7:0] sel);
    exp_flag.push_back(32'h0001_0000);
    exp_flag.push_back(32'h0);
    push_reads(sel);
  endtask

  task automatic start_job(input logic [20:0] nw, input logic [7:0] sel);
    @(posedge clk); #1;
    start = 1'b1; num_words = nw; set_sel = sel;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 400);
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic q_empty(input string tag);
    chk(tag, exp_wr.size() + exp_rd.size() + exp_res.size() + exp_flag.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] words[3];
    wr_t w;
    int  i, step, d0, r0, k0, k;
    logic acc;
    words[0] = 32'hA1; words[1] = 32'hA2; words[2] = 32'hA3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {24'b0, busy, done, mem_we, mem_rd_req, flag_we, src_ready, res_valid, timeout_err}, 32'd0);
    chk("rst_addr", {11'b0, mem_addr}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Load of 3 words with a valid gap, set 2
    for (int j = 0; j < 3; j++) begin w.a = 21'(j); w.d = words[j]; exp_wr.push_back(w); end
    push_job(8'd2);
    k0 = kick_cnt; d0 = done_cnt; r0 = res_cnt;
    @(posedge clk); #1;
    start = 1'b1; num_words = 21'd3; set_sel = 8'd2; src_valid = 1'b1; src_data = words[0];
    @(posedge clk); #1 start = 1'b0;
    i = 0; step = 0;
    while (i < 3 && step < 50) begin
      @(negedge clk); acc = src_valid && src_ready;
      @(posedge clk); #1;
      if (acc) i++;
      step++;
      src_valid = (i < 3) && (step != 2);
      src_data  = (i < 3) ? words[i] : 32'h0;
    end
    src_valid = 1'b0;
    chk("load_accepted", i, 32'd3);
    wait_idle("jobA_idle");
    chk("jobA_kick_once", kick_cnt - k0, 32'd1);
    chk("jobA_done", done_cnt - d0, 32'd1);
    chk("jobA_res", res_cnt - r0, 32'd4);
    q_empty("jobA_q");

    // num_words=0: KICK the cycle after start, no writes
    push_job(8'd0);
    d0 = done_cnt;
    start_job(21'd0, 8'd0);
    @(negedge clk);
    chk("nw0_kick", {31'b0, flag_we}, 32'd1);
    wait_idle("nw0_idle");
    chk("nw0_done", done_cnt - d0, 32'd1);
    q_empty("nw0_q");

    // Starts during WAIT_DONE are ignored
    push_job(8'd1);
    d0 = done_cnt;
    start_job(21'd0, 8'd1);
    k = 0;
    while (flag_rdata != 32'h2 && k < 100) begin @(negedge clk); k++; end
    chk("ack_seen", flag_rdata, 32'h2);
    repeat (2) @(posedge clk);
    for (int j = 0; j < 3; j++) start_job(21'd5, 8'd7);
    wait_idle("busy_start_idle");
    repeat (30) @(negedge clk);
    chk("busy_start_one_done", done_cnt - d0, 32'd1);
    q_empty("busy_start_q");

    // Timeout: flag never acknowledges
    flag_mode = 1'b0;
    exp_flag.push_back(32'h0001_0000);
    exp_flag.push_back(32'h0);
    d0 = done_cnt; r0 = res_cnt;
    start_job(21'd0, 8'd0);
    wait_idle("tmo_idle");
    chk("tmo_cycles", clr_cyc - kick_cyc, 32'd17);
    chk("tmo_err", {31'b0, timeout_err}, 32'd1);
    chk("tmo_no_res", res_cnt - r0, 32'd0);
    chk("tmo_no_done", done_cnt - d0, 32'd0);
    repeat (3) @(negedge clk);
    chk("tmo_err_hold", {31'b0, timeout_err}, 32'd1);
    q_empty("tmo_q");
    flag_mode = 1'b1;
    push_job(8'd5);
    start_job(21'd0, 8'd5);
    chk("tmo_err_clr", {31'b0, timeout_err}, 32'd0);
    wait_idle("after_tmo_idle");
    q_empty("after_tmo_q");

    // Reset in RD_WAIT after two results
    push_job(8'd3);
    d0 = done_cnt; r0 = res_cnt;
    start_job(21'd0, 8'd3);
    k = 0;
    while (res_cnt - r0 < 2 && k < 200) begin @(negedge clk); k++; end
    chk("rst_two_res", res_cnt - r0, 32'd2);
    k = 0;
    while (!mem_rd_req && k < 20) begin @(negedge clk); k++; end
    chk("rst_rdreq_seen", {31'b0, mem_rd_req}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {24'b0, busy, done, mem_we, mem_rd_req, flag_we, src_ready, res_valid, timeout_err}, 32'd0);
    chk("mid_rst_addr", {11'b0, mem_addr}, 32'd0);
    exp_rd.delete();
    exp_res.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_no_done", done_cnt - d0, 32'd0);
    q_empty("post_rst_q");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
